// File: rtl/hazard_unit_if.sv
// Hazard-control bundle between the 5-stage pipeline and hazard_unit:
// dependency/status inputs toward the unit, latch enables/flushes and perf counters back.
interface hazard_unit_if;
   logic        ihit;
   logic        dhit;
   logic        exm_dREN;
   logic        exm_dWEN;
   logic        exm_redirect;
   logic        idex_dREN;
   logic        idex_datomic;
   logic [4:0]  idex_wsel;
   logic [4:0]  ifid_rs;
   logic [4:0]  ifid_rt;
   logic        ifid_uses_rt;
   logic        mwb_halt;

   logic        pc_en;
   logic        ifid_en;
   logic        idex_en;
   logic        exm_en;
   logic        mwb_en;
   logic        ifid_flush;
   logic        idex_flush;
   logic        exm_flush;
   logic [31:0] stall_cycles;
   logic [31:0] flush_events;

   // Pipeline side: reports hazards, consumes latch controls.
   modport master (
      output ihit, dhit, exm_dREN, exm_dWEN, exm_redirect,
             idex_dREN, idex_datomic, idex_wsel, ifid_rs, ifid_rt,
             ifid_uses_rt, mwb_halt,
      input  pc_en, ifid_en, idex_en, exm_en, mwb_en,
             ifid_flush, idex_flush, exm_flush, stall_cycles, flush_events
   );

   // Hazard unit side.
   modport slave (
      input  ihit, dhit, exm_dREN, exm_dWEN, exm_redirect,
             idex_dREN, idex_datomic, idex_wsel, ifid_rs, ifid_rt,
             ifid_uses_rt, mwb_halt,
      output pc_en, ifid_en, idex_en, exm_en, mwb_en,
             ifid_flush, idex_flush, exm_flush, stall_cycles, flush_events
   );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use/LL-use stalls, D-mem freeze, I-miss bubbles, redirect and halt.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_unit #(
   parameter int unsigned LL_BUBBLES = 2
) (
   input  logic         CLK,
   input  logic         RST,
   hazard_unit_if.slave hif
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      BUBBLE = 2'd1,
      DWAIT  = 2'd2,
      HALTED = 2'd3
   } state_t;

   localparam logic [1:0] LL_INIT = 2'(LL_BUBBLES - 1);

   state_t     state;
   state_t     state_next;
   state_t     ret_state;
   state_t     ret_next;
   state_t     eff_state;
   logic [1:0] bcnt;
   logic [1:0] bcnt_next;

   logic dep;
   logic mem_wait;
   logic halt_cond;

   logic pc_en;
   logic ifid_en;
   logic idex_en;
   logic exm_en;
   logic mwb_en;
   logic ifid_flush;
   logic idex_flush;
   logic exm_flush;

   always_comb begin
      dep = hif.idex_dREN && (hif.idex_wsel != '0) &&
            ((hif.idex_wsel == hif.ifid_rs) ||
             (hif.ifid_uses_rt && (hif.idex_wsel == hif.ifid_rt)));
      mem_wait  = (hif.exm_dREN || hif.exm_dWEN) && !hif.dhit;
      halt_cond = (state == HALTED) || hif.mwb_halt;
      // On the dhit cycle DWAIT behaves exactly like the state it froze.
      eff_state = (state == DWAIT) ? ret_state : state;
   end

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= RUN;
         ret_state <= RUN;
         bcnt      <= '0;
      end else begin
         state     <= state_next;
         ret_state <= ret_next;
         bcnt      <= bcnt_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = eff_state;
      ret_next   = ret_state;
      bcnt_next  = bcnt;
      if (halt_cond) begin
         state_next = HALTED;
      end else if (mem_wait) begin
         state_next = DWAIT;
         ret_next   = eff_state;
      end else if (hif.exm_redirect) begin
         state_next = RUN;
         bcnt_next  = '0;
      end else if (eff_state == BUBBLE) begin
         if (bcnt <= 2'd1) begin
            state_next = RUN;
            bcnt_next  = '0;
         end else begin
            bcnt_next  = bcnt - 2'd1;
         end
      end else if (dep && hif.idex_datomic && (LL_BUBBLES > 1)) begin
         state_next = BUBBLE;
         bcnt_next  = LL_INIT;
      end
   end

   // Output logic
   always_comb begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exm_en     = 1'b0;
      mwb_en     = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      exm_flush  = 1'b0;
      if (RST || halt_cond || mem_wait) begin
         pc_en = 1'b0;
      end else if (hif.exm_redirect) begin
         pc_en      = 1'b1;
         ifid_en    = 1'b1;
         idex_en    = 1'b1;
         exm_en     = 1'b1;
         mwb_en     = 1'b1;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         exm_flush  = 1'b1;
      end else if ((eff_state == BUBBLE) || dep) begin
         idex_en    = 1'b1;
         exm_en     = 1'b1;
         mwb_en     = 1'b1;
         idex_flush = 1'b1;
      end else if (!hif.ihit) begin
         ifid_en    = 1'b1;
         idex_en    = 1'b1;
         exm_en     = 1'b1;
         mwb_en     = 1'b1;
         ifid_flush = 1'b1;
      end else begin
         pc_en      = 1'b1;
         ifid_en    = 1'b1;
         idex_en    = 1'b1;
         exm_en     = 1'b1;
         mwb_en     = 1'b1;
      end
   end

   assign hif.pc_en      = pc_en;
   assign hif.ifid_en    = ifid_en;
   assign hif.idex_en    = idex_en;
   assign hif.exm_en     = exm_en;
   assign hif.mwb_en     = mwb_en;
   assign hif.ifid_flush = ifid_flush;
   assign hif.idex_flush = idex_flush;
   assign hif.exm_flush  = exm_flush;

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_q;
   logic [31:0] flush_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!pc_en && (state != HALTED)) stall_q <= stall_q + 32'd1;
         if (hif.exm_redirect)            flush_q <= flush_q + 32'd1;
      end
   end

   assign hif.stall_cycles = stall_q;
   assign hif.flush_events = flush_q;
`else
   assign hif.stall_cycles = '0;
   assign hif.flush_events = '0;
`endif

endmodule

// File: doc/hazard_unit.md
# hazard_unit

- Pipeline control block for the 5-stage core.
- Decides each cycle which pipeline latches advance, hold or take a bubble, based on:
  - load-use and LL-use dependencies,
  - data-memory waits, instruction-fetch misses,
  - control redirects and halt.
- Sits beside the forward unit. It covers the dependencies forwarding cannot resolve, so that by the time a consumer reaches EX its operand is in EX/MEM or MEM/WB for forwarding.
- Drives the enable/flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB latches.

## Interface
Parameters:
- LL_BUBBLES, 2: bubbles inserted behind an LL (atomic load) whose result is used by the next instruction; legal range 1..3.

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- ihit  in  1  instruction fetch completed this cycle
- dhit  in  1  data access completed this cycle
- exm_dREN, exm_dWEN  in  1 each  memory op in MEM stage
- exm_redirect  in  1  taken branch/jump resolved in MEM stage
- idex_dREN  in  1  EX-stage instruction is a load
- idex_datomic  in  1  EX-stage load is LL
- idex_wsel  in  5  EX-stage destination register
- ifid_rs, ifid_rt  in  5 each  ID-stage source registers
- ifid_uses_rt  in  1  ID-stage instruction reads rt as a source
- mwb_halt  in  1  HALT reached WB
- pc_en, ifid_en, idex_en, exm_en, mwb_en  out  1 each  latch enables
- ifid_flush, idex_flush, exm_flush  out  1 each  load a bubble (all-zero control) on next edge; only meaningful with the matching enable high
- stall_cycles  out  32  performance counter (see Configuration)
- flush_events  out  32  performance counter (see Configuration)

## Operation
State encoding: RUN, BUBBLE, DWAIT, HALTED. A 2-bit bubble counter `bcnt` is held with the state.

Dependency term: dep = idex_dREN & idex_wsel≠0 & (idex_wsel==ifid_rs | (ifid_uses_rt & idex_wsel==ifid_rt)).

Priority, highest first, evaluated combinationally each cycle:
1. HALTED state or mwb_halt: all enables 0; next state HALTED (sticky until RST).
2. (exm_dREN|exm_dWEN) & !dhit: all enables 0 (full freeze); next state DWAIT. DWAIT exits to the saved prior state (RUN or BUBBLE) on the dhit cycle. In DWAIT, `bcnt` is not decremented.
3. exm_redirect: all enables 1; ifid_flush = idex_flush = exm_flush = 1; next state RUN and `bcnt` cleared (this cancels any pending bubble).
4. dep in RUN:
   - Outputs: pc_en = ifid_en = 0; idex_flush = 1; idex_en = exm_en = mwb_en = 1.
   - If idex_datomic and LL_BUBBLES > 1: go to BUBBLE with `bcnt` = LL_BUBBLES−1.
   - Otherwise stay in RUN. One bubble is enough, because the bubble clears idex_dREN.
5. BUBBLE: same outputs as item 4. Decrement `bcnt` each cycle; go to RUN when `bcnt` reaches 0.
6. !ihit in RUN: pc_en = 0; ifid_en = 1 with ifid_flush = 1 (bubble into ID); downstream latches enabled.
7. Otherwise all enables 1 and all flushes 0.

Additional rules:
- ifid_rs/rt equal to 0 never creates a dependency.
- While RST is high, all enables and flushes are forced to 0. State resets to RUN and `bcnt` to 0.

## Timing
- All outputs are combinational from the current state and inputs. There is no added latency: a hazard detected in cycle t is acted on at the edge ending cycle t.
- Load-use costs exactly 1 cycle. LL-use costs LL_BUBBLES cycles.
- A DWAIT freeze is extended by as many cycles as dhit stays low.
- A redirect in the same cycle as dep discards the stall. The dependent instruction is flushed anyway.
- RST asserted mid-BUBBLE or mid-DWAIT returns to RUN immediately (asynchronous). The first edge after RST deasserts behaves as RUN.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cycles increments every cycle in which pc_en = 0 and the state is not HALTED.
  - flush_events increments on each exm_redirect cycle.
  - Both counters reset to 0 and wrap modulo 2^32.
- HAZARD_PERF_EN undefined: both ports are present but tied to 0, and no counter flops exist.

## Test plan
- Load-use: LW to r5 in EX, ADD reading r5 as rs in ID → one cycle with pc_en = 0, ifid_en = 0, idex_flush = 1; next cycle all enables 1.
- Zero register: LW to r0 in EX, ID reads r0 → no stall.
- LL-use with LL_BUBBLES = 2: LL to r3 in EX, SC using r3 in ID → exactly 2 stall cycles; with HAZARD_PERF_EN, stall_cycles advances by 2.
- DWAIT during BUBBLE: dhit low for 3 cycles during the second LL bubble → all enables 0 for 3 cycles, then the remaining bubble is completed, then RUN.
- Redirect vs load-use: exm_redirect and dep in the same cycle → ifid_flush = idex_flush = exm_flush = 1, pc_en = 1, state RUN; flush_events +1.
- Halt and reset: mwb_halt pulsed → enables stay 0 for 10 cycles with no input effect; RST pulse → state RUN, counters 0.
